// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit:
// operation encodings, the control state type and small op decoders.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/multi_cycle_muldiv_if.sv
// Request/response bundle between a requester and the multi-cycle
// multiply/divide unit.
interface multi_cycle_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic             cancel;
    logic [WIDTH-1:0] In1;
    logic [WIDTH-1:0] In2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, cancel, In1, In2,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, cancel, In1, In2,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negation; used both to take operand
// magnitudes and to put the sign back onto results.
module muldiv_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/multi_cycle_muldiv.sv
// Iterative signed/unsigned multiplier and restoring divider. One result
// bit per cycle on operand magnitudes in a shared 2*WIDTH accumulator,
// followed by a single sign-correction cycle.
module multi_cycle_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    multi_cycle_muldiv_if.slave  bus
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    state_t            state_reg;
    logic [1:0]        op_reg;
    logic [WIDTH-1:0]  b_reg;       // divisor / multiplicand magnitude
    logic              neg_q_reg;   // product or quotient needs negation
    logic              neg_r_reg;   // remainder takes dividend's sign
    logic [W2-1:0]     acc_reg;
    logic [CW-1:0]     count_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              dbz_reg;
    logic [WIDTH-1:0]  hi_reg;
    logic [WIDTH-1:0]  lo_reg;

    logic [WIDTH-1:0]  abs_a_value;
    logic              abs_a_negate;
    logic [WIDTH-1:0]  abs_a_out;
    logic              abs_b_negate;
    logic [WIDTH-1:0]  abs_b_out;
    logic [W2-1:0]     res_value;
    logic [W2-1:0]     res_out;

    logic [WIDTH-1:0]  mul_addend;
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_trial;
    logic [WIDTH:0]    div_diff;
    logic              div_fits;
    logic [W2-1:0]     acc_next;

    // The dividend-side negator is idle during FIX, so it is reused there
    // to give the remainder the dividend's sign.
    assign abs_a_value  = (state_reg == FIX) ? acc_reg[W2-1:WIDTH] : bus.In1;
    assign abs_a_negate = (state_reg == FIX) ? neg_r_reg
                                             : (op_is_signed(bus.op) & bus.In1[WIDTH-1]);
    assign abs_b_negate = op_is_signed(bus.op) & bus.In2[WIDTH-1];

    // Quotient is zero-extended so the full-width negator yields -q in the low half.
    assign res_value = op_is_div(op_reg) ? {{WIDTH{1'b0}}, acc_reg[WIDTH-1:0]} : acc_reg;

    muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (
        .value  (abs_a_value),
        .negate (abs_a_negate),
        .result (abs_a_out)
    );

    muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (
        .value  (bus.In2),
        .negate (abs_b_negate),
        .result (abs_b_out)
    );

    muldiv_abs #(.WIDTH(W2)) u_abs_res (
        .value  (res_value),
        .negate (neg_q_reg),
        .result (res_out)
    );

    // One iteration: right-shift shift-add for multiply, left-shift
    // restoring subtract for divide.
    always_comb begin
        mul_addend = acc_reg[0] ? b_reg : {WIDTH{1'b0}};
        mul_sum    = {1'b0, acc_reg[W2-1:WIDTH]} + {1'b0, mul_addend};
        div_trial  = acc_reg[W2-1:WIDTH-1];
        div_fits   = (div_trial >= {1'b0, b_reg});
        div_diff   = div_trial - {1'b0, b_reg};
        acc_next   = {mul_sum, acc_reg[WIDTH-1:1]};
        if (op_is_div(op_reg)) begin
            acc_next = {(div_fits ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                        acc_reg[WIDTH-2:0], div_fits};
        end
    end

    // Control FSM with registered status and result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            op_reg    <= 2'b00;
            b_reg     <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            acc_reg   <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            dbz_reg   <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start && !bus.cancel) begin
                        state_reg <= CALC;
                        busy_reg  <= 1'b1;
                        op_reg    <= bus.op;
                        acc_reg   <= {{WIDTH{1'b0}}, abs_a_out};
                        b_reg     <= abs_b_out;
                        neg_q_reg <= op_is_signed(bus.op) & (bus.In1[WIDTH-1] ^ bus.In2[WIDTH-1]);
                        neg_r_reg <= op_is_signed(bus.op) & bus.In1[WIDTH-1];
                        count_reg <= CW'(WIDTH);
                    end
                end
                CALC: begin
                    if (bus.cancel) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        acc_reg   <= acc_next;
                        count_reg <= count_reg - CW'(1);
                        if (count_reg == CW'(1)) begin
                            state_reg <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (bus.cancel) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        if (op_is_div(op_reg)) begin
                            // Divide by zero: quotient forced to all ones; the
                            // remainder path already reproduces the dividend.
                            hi_reg  <= abs_a_out;
                            lo_reg  <= (b_reg == '0) ? {WIDTH{1'b1}} : res_out[WIDTH-1:0];
                            dbz_reg <= (b_reg == '0);
                        end else begin
                            hi_reg  <= res_out[W2-1:WIDTH];
                            lo_reg  <= res_out[WIDTH-1:0];
                            dbz_reg <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.hi          = hi_reg;
    assign bus.lo          = lo_reg;
    assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_multi_cycle_muldiv.sv
// Scoreboard bench: drivers push expected results when issuing an op, a
// negedge monitor pops and compares on every done pulse.
module tb_multi_cycle_muldiv;
    import muldiv_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multi_cycle_muldiv_if #(.WIDTH(32)) bus32();
    multi_cycle_muldiv_if #(.WIDTH(8))  bus8();

    multi_cycle_muldiv #(.WIDTH(32)) dut32 (.clk(clk), .reset(rst_n), .bus(bus32));
    multi_cycle_muldiv #(.WIDTH(8))  dut8  (.clk(clk), .reset(rst_n), .bus(bus8));

    int   n_checks = 0;
    int   n_fail   = 0;
    int   done32_cnt = 0;
    int   done8_cnt  = 0;
    exp_t q32[$];
    exp_t q8[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus32.done === 1'b1) begin
            done32_cnt++;
            if (q32.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done32_unexpected: got hi=%h lo=%h, expected no done", bus32.hi, bus32.lo);
            end else begin
                e = q32.pop_front();
                $display("txn32 hi=%h lo=%h dbz=%b (exp %h %h %b)", bus32.hi, bus32.lo,
                         bus32.div_by_zero, e.hi, e.lo, e.dbz);
                check("hi32",  64'(bus32.hi), 64'(e.hi));
                check("lo32",  64'(bus32.lo), 64'(e.lo));
                check("dbz32", 64'(bus32.div_by_zero), 64'(e.dbz));
            end
        end
        if (bus8.done === 1'b1) begin
            done8_cnt++;
            if (q8.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done8_unexpected: got hi=%h lo=%h, expected no done", bus8.hi, bus8.lo);
            end else begin
                e = q8.pop_front();
                $display("txn8 hi=%h lo=%h dbz=%b (exp %h %h %b)", bus8.hi, bus8.lo,
                         bus8.div_by_zero, e.hi[7:0], e.lo[7:0], e.dbz);
                check("hi8",  64'(bus8.hi), 64'(e.hi));
                check("lo8",  64'(bus8.lo), 64'(e.lo));
                check("dbz8", 64'(bus8.div_by_zero), 64'(e.dbz));
            end
        end
    end

    // Behavioural reference for the 8-bit instance.
    function automatic exp_t model8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t        m;
        int          sa;
        int          sb;
        int          ua;
        int          ub;
        logic [31:0] p;
        logic [31:0] q;
        logic [31:0] r;
        sa = $signed(a);
        sb = $signed(b);
        ua = int'(a);
        ub = int'(b);
        m  = '0;
        if (op == OP_MULT || op == OP_MULTU) begin
            p    = (op == OP_MULT) ? 32'(sa * sb) : 32'(ua * ub);
            m.hi = {24'd0, p[15:8]};
            m.lo = {24'd0, p[7:0]};
        end else if (b == 8'd0) begin
            m.hi  = {24'd0, a};
            m.lo  = 32'h0000_00FF;
            m.dbz = 1'b1;
        end else begin
            q    = (op == OP_DIV) ? 32'(sa / sb) : 32'(ua / ub);
            r    = (op == OP_DIV) ? 32'(sa % sb) : 32'(ua % ub);
            m.hi = {24'd0, r[7:0]};
            m.lo = {24'd0, q[7:0]};
        end
        return m;
    endfunction

    // Call at a negedge; returns #1 after the acceptance edge.
    task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus32.op    = op;
        bus32.In1   = a;
        bus32.In2   = b;
        bus32.start = 1'b1;
        @(posedge clk);
        #1 bus32.start = 1'b0;
    endtask

    task automatic wait_done32(output int cyc, output logic seen, output logic busy1, output logic busy_d);
        cyc = 0; seen = 1'b0; busy1 = 1'b0; busy_d = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) busy1 = bus32.busy;
            if (bus32.done === 1'b1) begin
                seen   = 1'b1;
                busy_d = bus32.busy;
            end
        end
    endtask

    task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                         input bit chk_lat);
        exp_t e;
        int   cyc;
        logic seen, busy1, busy_d;
        e.hi = ehi; e.lo = elo; e.dbz = edbz;
        q32.push_back(e);
        issue32(op, a, b);
        wait_done32(cyc, seen, busy1, busy_d);
        check("done32_seen", 64'(seen), 64'(1));
        if (chk_lat) begin
            check("latency32", 64'(cyc), 64'(34));
            check("busy_after_accept", 64'(busy1), 64'(1));
            check("busy_in_done", 64'(busy_d), 64'(0));
        end
        @(negedge clk);
    endtask

    task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int   cyc;
        logic seen;
        q8.push_back(model8(op, a, b));
        bus8.op    = op;
        bus8.In1   = a;
        bus8.In2   = b;
        bus8.start = 1'b1;
        @(posedge clk);
        #1 bus8.start = 1'b0;
        cyc = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (bus8.done === 1'b1) seen = 1'b1;
        end
        check("done8_seen", 64'(seen), 64'(1));
        check("latency8", 64'(cyc), 64'(10));
        @(negedge clk);
    endtask

    initial begin
        int          base;
        logic [7:0]  corners [8];
        rst_n = 1'b0;
        bus32.start = 1'b0; bus32.cancel = 1'b0; bus32.op = 2'b00; bus32.In1 = '0; bus32.In2 = '0;
        bus8.start  = 1'b0; bus8.cancel  = 1'b0; bus8.op  = 2'b00; bus8.In1  = '0; bus8.In2  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus32.busy), 64'(0));
        check("rst_done", 64'(bus32.done), 64'(0));
        check("rst_hi",   64'(bus32.hi), 64'(0));
        check("rst_lo",   64'(bus32.lo), 64'(0));
        check("rst_dbz",  64'(bus32.div_by_zero), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed WIDTH=32 vectors.
        run32(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b1);
        run32(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        run32(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
        run32(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run32(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run32(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run32(OP_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1, 1'b1);
        run32(OP_DIVU,  32'h0000_0009, 32'h0000_0004, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
        run32(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // start pulsed on cycle 5 of a busy MULT must be ignored.
        base = done32_cnt;
        begin
            exp_t e;
            e.hi = 32'h0; e.lo = 32'h2A; e.dbz = 1'b0;
            q32.push_back(e);
        end
        issue32(OP_MULT, 32'd6, 32'd7);
        repeat (5) @(negedge clk);
        bus32.op = OP_DIVU; bus32.In1 = 32'd100; bus32.In2 = 32'd3; bus32.start = 1'b1;
        @(negedge clk);
        bus32.start = 1'b0;
        repeat (50) @(negedge clk);
        check("ignored_start_done_count", 64'(done32_cnt - base), 64'(1));

        // cancel on cycle 10 of a DIV: no done, outputs hold 0 / 0x2A.
        base = done32_cnt;
        issue32(OP_DIV, 32'd100, 32'd3);
        repeat (10) @(negedge clk);
        bus32.cancel = 1'b1;
        @(posedge clk);
        #1 bus32.cancel = 1'b0;
        @(negedge clk);
        check("cancel_busy", 64'(bus32.busy), 64'(0));
        check("cancel_done", 64'(bus32.done), 64'(0));
        check("cancel_hi",   64'(bus32.hi), 64'(0));
        check("cancel_lo",   64'(bus32.lo), 64'(32'h2A));
        repeat (50) @(negedge clk);
        check("cancel_done_count", 64'(done32_cnt - base), 64'(0));

        // reset on cycle 20 of a MULT: everything clears at once, no done.
        base = done32_cnt;
        issue32(OP_MULT, 32'd3, 32'd4);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(bus32.busy), 64'(0));
        check("midrst_done", 64'(bus32.done), 64'(0));
        check("midrst_hi",   64'(bus32.hi), 64'(0));
        check("midrst_lo",   64'(bus32.lo), 64'(0));
        check("midrst_dbz",  64'(bus32.div_by_zero), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("midrst_done_count", 64'(done32_cnt - base), 64'(0));
        run32(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b1);

        // WIDTH=8: all ops over corner operands, then random pairs.
        corners[0] = 8'h00; corners[1] = 8'h01; corners[2] = 8'h02; corners[3] = 8'h7F;
        corners[4] = 8'h80; corners[5] = 8'h81; corners[6] = 8'hFE; corners[7] = 8'hFF;
        for (int op = 0; op < 4; op++) begin
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 8; j++) begin
                    run8(2'(op), corners[i], corners[j]);
                end
            end
        end
        for (int k = 0; k < 200; k++) begin
            run8(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        check("q32_drained", 64'(q32.size()), 64'(0));
        check("q8_drained",  64'(q8.size()),  64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
